// File: rtl/bank_pingpong_ctrl_pkg.sv
// Shared constants and read-FSM state type for the ME reference-bank ping-pong controller.
package me_dmt_pkg;
    localparam int PIXEL  = 8;
    localparam int LANES  = 8;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int DATA_W = LANES * PIXEL;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } rd_state_e;
endpackage

// File: rtl/bank_pingpong_ctrl_if.sv
// Fetch stream, sweep control and bank-side signals of the ping-pong controller.
interface bank_pingpong_ctrl_if;
    import me_dmt_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              sweep_start;
    logic              sweep_keep;
    logic              sweep_busy;
    logic              sweep_done;
    logic              beg_en;
    logic [DATA_W-1:0] ref_in;
    logic [ADDR_W-1:0] wr_addr;
    logic              Bank_sel;
    logic [ADDR_W-1:0] address;
    logic              rd_en;
    logic              out_valid;
    logic [1:0]        bank_full;

    modport master (
        output in_valid, in_data, sweep_start, sweep_keep,
        input  in_ready, sweep_busy, sweep_done, beg_en, ref_in, wr_addr,
               Bank_sel, address, rd_en, out_valid, bank_full
    );

    modport slave (
        input  in_valid, in_data, sweep_start, sweep_keep,
        output in_ready, sweep_busy, sweep_done, beg_en, ref_in, wr_addr,
               Bank_sel, address, rd_en, out_valid, bank_full
    );
endinterface

// File: rtl/bank_pingpong_ctrl_addr_gen.sv
// DEPTH-wrapping bank address counter; DEPTH is a power of two so the natural wrap is exact.
module bank_addr_gen
    import me_dmt_pkg::*;
#(
    parameter int W = ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         last
);
    assign last = &count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   count <= '0;
        else if (clr) count <= '0;
        else if (en)  count <= count + 1'b1;
    end
endmodule

// File: rtl/bank_pingpong_ctrl.sv
// Ping-pong sequencing of two reference-pixel banks: one filled from the fetch stream, the other swept.
//   state | meaning
//   IDLE  | no sweep; bank swap may occur here
//   READ  | rd_en low, address stepping 0..DEPTH-1
//   DRAIN | last word on bank output, sweep_done, optional release of read bank
module bank_pingpong_ctrl
    import me_dmt_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    bank_pingpong_ctrl_if.slave  bus
);
    rd_state_e         state, state_nxt;
    logic              ready_en;
    logic              sel;
    logic [1:0]        bank_full;
    logic              keep_q;
    logic              xfer;
    logic              swap;
    logic              rd_step;
    logic              rd_en_c;
    logic              busy_c;
    logic              done_c;
    logic [ADDR_W-1:0] fill_cnt;
    logic [ADDR_W-1:0] rd_cnt;
    logic              fill_last;
    logic              rd_last;

    assign bus.in_ready   = ready_en && !bank_full[sel];
    assign xfer           = bus.in_valid && bus.in_ready;
    // Swap needs the write bank full, the read bank released and no sweep touching it.
    assign swap           = bank_full[sel] && !bank_full[~sel] && (state == IDLE);
    assign bus.Bank_sel   = sel;
    assign bus.bank_full  = bank_full;
    assign bus.address    = rd_cnt;
    assign bus.rd_en      = rd_en_c;
    assign bus.sweep_busy = busy_c;
    assign bus.sweep_done = done_c;

    bank_addr_gen u_fill_addr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (xfer),
        .clr   (1'b0),
        .count (fill_cnt),
        .last  (fill_last)
    );

    bank_addr_gen u_rd_addr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (rd_step),
        .clr   (state == DRAIN),
        .count (rd_cnt),
        .last  (rd_last)
    );

    always_comb begin
        state_nxt = state;
        rd_en_c   = 1'b1;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        rd_step   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.sweep_start && bank_full[~sel]) state_nxt = READ;
            end
            READ: begin
                rd_en_c = 1'b0;
                busy_c  = 1'b1;
                rd_step = 1'b1;
                if (rd_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy_c    = 1'b1;
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ready_en      <= 1'b0;
            sel           <= 1'b0;
            bank_full     <= 2'b00;
            keep_q        <= 1'b0;
            bus.beg_en    <= 1'b0;
            bus.ref_in    <= '0;
            bus.wr_addr   <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            state         <= state_nxt;
            ready_en      <= 1'b1;
            bus.beg_en    <= xfer;
            bus.out_valid <= (state == READ);
            if (xfer) begin
                bus.ref_in  <= bus.in_data;
                bus.wr_addr <= fill_cnt;
            end
            if (xfer && fill_last) bank_full[sel] <= 1'b1;
            if ((state == DRAIN) && !keep_q) bank_full[~sel] <= 1'b0;
            if ((state == IDLE) && (state_nxt == READ)) keep_q <= bus.sweep_keep;
            if (swap) sel <= ~sel;
        end
    end
endmodule

// File: tb/tb_bank_pingpong_ctrl.sv
// Scenario bench for bank_pingpong_ctrl: write scoreboard plus cycle-exact sweep schedule checks.
module tb_bank_pingpong_ctrl;
    import me_dmt_pkg::*;

    typedef struct packed {
        logic              sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bank_pingpong_ctrl_if bif ();

    bank_pingpong_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

    wr_t  wq[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_waddr = 0;
    logic exp_sel = 1'b0;

    localparam logic [DATA_W-1:0] D0F = {8{8'h0F}};
    localparam logic [DATA_W-1:0] D55 = {8{8'h55}};
    localparam logic [DATA_W-1:0] D33 = {8{8'h33}};
    localparam logic [DATA_W-1:0] DAA = {8{8'hAA}};
    localparam logic [DATA_W-1:0] DC3 = {8{8'hC3}};

    // Every bank write must match the oldest accepted fetch word.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && bif.beg_en === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL wr_unexpected sel=%0b addr=%0d data=%h", bif.Bank_sel, bif.wr_addr, bif.ref_in);
            end else begin
                e = wq.pop_front();
                if ({bif.Bank_sel, bif.wr_addr, bif.ref_in} !== e) begin
                    failures++;
                    $display("FAIL wr_data got sel=%0b addr=%0d data=%h expected sel=%0b addr=%0d data=%h",
                             bif.Bank_sel, bif.wr_addr, bif.ref_in, e.sel, e.addr, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_words(input int n, input logic [DATA_W-1:0] d, input int budget, output int cycles);
        int  acc;
        wr_t w;
        acc = 0;
        cycles = 0;
        while (acc < n && cycles < budget) begin
            step();
            bif.in_valid = 1'b1;
            bif.in_data  = d;
            @(negedge clk);
            cycles++;
            if (bif.in_ready === 1'b1) begin
                w.sel  = exp_sel;
                w.addr = exp_waddr[ADDR_W-1:0];
                w.data = d;
                wq.push_back(w);
                exp_waddr = (exp_waddr + 1) % DEPTH;
                acc++;
            end
        end
        step();
        bif.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (acc != n) begin
            failures++;
            $display("FAIL fill_timeout accepted=%0d expected=%0d", acc, n);
        end
    endtask

    // Cycle 0 carries sweep_start; cycles 1..DEPTH are READ, cycle DEPTH+1 is DRAIN.
    task automatic do_sweep(input logic keep, input logic [1:0] exp_bf, input int extra_a, input int extra_b);
        logic [ADDR_W-1:0] ea;
        logic              er, eo, ed;
        step();
        bif.sweep_start = 1'b1;
        bif.sweep_keep  = keep;
        @(negedge clk);
        checks++;
        if ({bif.bank_full, bif.Bank_sel, bif.sweep_busy} !== {exp_bf, exp_sel, 1'b0}) begin
            failures++;
            $display("FAIL sweep_start_state got full=%b sel=%0b busy=%0b expected full=%b sel=%0b busy=0",
                     bif.bank_full, bif.Bank_sel, bif.sweep_busy, exp_bf, exp_sel);
        end
        for (int k = 1; k <= DEPTH + 1; k++) begin
            step();
            bif.sweep_start = (k == extra_a) || (k == extra_b);
            bif.sweep_keep  = ~keep;
            @(negedge clk);
            er = (k > DEPTH);
            ea = (k <= DEPTH) ? ADDR_W'(k - 1) : '0;
            eo = (k >= 2);
            ed = (k == DEPTH + 1);
            checks++;
            if ({bif.rd_en, bif.address, bif.out_valid, bif.sweep_done, bif.sweep_busy} !== {er, ea, eo, ed, 1'b1}) begin
                failures++;
                $display("FAIL sweep_cycle k=%0d got rd_en=%0b addr=%0d ov=%0b done=%0b busy=%0b expected rd_en=%0b addr=%0d ov=%0b done=%0b busy=1",
                         k, bif.rd_en, bif.address, bif.out_valid, bif.sweep_done, bif.sweep_busy, er, ea, eo, ed);
            end
        end
    endtask

    task automatic check_side(input string name, input logic [1:0] bf, input logic sl, input logic rdy);
        checks++;
        if ({bif.bank_full, bif.Bank_sel, bif.in_ready} !== {bf, sl, rdy}) begin
            failures++;
            $display("FAIL %s got full=%b sel=%0b ready=%0b expected full=%b sel=%0b ready=%0b",
                     name, bif.bank_full, bif.Bank_sel, bif.in_ready, bf, sl, rdy);
        end
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if ({bif.in_ready, bif.sweep_busy, bif.sweep_done, bif.beg_en, bif.ref_in, bif.wr_addr,
             bif.Bank_sel, bif.address, bif.rd_en, bif.out_valid, bif.bank_full} !==
            {1'b0, 1'b0, 1'b0, 1'b0, {DATA_W{1'b0}}, {ADDR_W{1'b0}},
             1'b0, {ADDR_W{1'b0}}, 1'b1, 1'b0, 2'b00}) begin
            failures++;
            $display("FAIL %s got ready=%0b busy=%0b done=%0b beg=%0b ref=%h wa=%0d sel=%0b addr=%0d rd_en=%0b ov=%0b full=%b expected reset values",
                     name, bif.in_ready, bif.sweep_busy, bif.sweep_done, bif.beg_en, bif.ref_in, bif.wr_addr,
                     bif.Bank_sel, bif.address, bif.rd_en, bif.out_valid, bif.bank_full);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        check_reset_vals("reset_values");
        rst_n = 1'b1;
        check_side("ready_at_release", 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        check_side("ready_after_release", 2'b00, 1'b0, 1'b1);
    endtask

    task automatic test_fill_bank0();
        int c;
        fill_words(DEPTH, D0F, 200, c);
        checks++;
        if (c != DEPTH) begin
            failures++;
            $display("FAIL fill0_stall cycles=%0d expected=%0d", c, DEPTH);
        end
        check_side("fill0_full", 2'b01, 1'b0, 1'b0);
        step();
        @(negedge clk);
        exp_sel = 1'b1;
        check_side("fill0_swap", 2'b01, 1'b1, 1'b1);
        checks++;
        if (wq.size() != 0) begin
            failures++;
            $display("FAIL fill0_pending got=%0d expected=0", wq.size());
        end
    endtask

    task automatic test_sweep_concurrent();
        int c;
        fork
            do_sweep(1'b0, 2'b01, -1, -1);
            begin
                fill_words(DEPTH, D55, 200, c);
                checks++;
                if (c != DEPTH) begin
                    failures++;
                    $display("FAIL fill1_stall cycles=%0d expected=%0d", c, DEPTH);
                end
            end
        join
        step();
        @(negedge clk);
        check_side("conc_after_drain", 2'b10, 1'b1, 1'b0);
        step();
        @(negedge clk);
        exp_sel = 1'b0;
        check_side("conc_swap", 2'b10, 1'b0, 1'b1);
    endtask

    task automatic test_both_full();
        int  c;
        wr_t w;
        fill_words(DEPTH, D33, 200, c);
        check_side("both_full", 2'b11, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            bif.in_valid = 1'b1;
            bif.in_data  = DAA;
            @(negedge clk);
            check_side("held_off", 2'b11, 1'b0, 1'b0);
        end
        do_sweep(1'b0, 2'b11, -1, -1);
        step();
        @(negedge clk);
        check_side("both_after_drain", 2'b01, 1'b0, 1'b0);
        step();
        @(negedge clk);
        exp_sel = 1'b1;
        check_side("both_ready_back", 2'b01, 1'b1, 1'b1);
        w.sel  = exp_sel;
        w.addr = exp_waddr[ADDR_W-1:0];
        w.data = DAA;
        wq.push_back(w);
        exp_waddr = (exp_waddr + 1) % DEPTH;
        step();
        bif.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_keep();
        int c;
        fill_words(DEPTH - 1, DAA, 200, c);
        check_side("keep_both_full", 2'b11, 1'b1, 1'b0);
        do_sweep(1'b1, 2'b11, -1, -1);
        do_sweep(1'b0, 2'b11, -1, -1);
        step();
        @(negedge clk);
        check_side("keep_after_second", 2'b10, 1'b1, 1'b0);
        step();
        @(negedge clk);
        exp_sel = 1'b0;
        check_side("keep_swap", 2'b10, 1'b0, 1'b1);
    endtask

    task automatic test_ignored();
        do_sweep(1'b0, 2'b10, 40, DEPTH + 1);
        step();
        bif.sweep_start = 1'b0;
        @(negedge clk);
        checks++;
        if ({bif.rd_en, bif.sweep_busy, bif.bank_full, bif.Bank_sel} !== {1'b1, 1'b0, 2'b00, 1'b0}) begin
            failures++;
            $display("FAIL drain_start_ignored got rd_en=%0b busy=%0b full=%b sel=%0b expected rd_en=1 busy=0 full=00 sel=0",
                     bif.rd_en, bif.sweep_busy, bif.bank_full, bif.Bank_sel);
        end
        step();
        bif.sweep_start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            step();
            bif.sweep_start = 1'b0;
            @(negedge clk);
            checks++;
            if ({bif.rd_en, bif.sweep_busy, bif.sweep_done, bif.out_valid} !== 4'b1000) begin
                failures++;
                $display("FAIL empty_start_ignored i=%0d got rd_en=%0b busy=%0b done=%0b ov=%0b expected 1/0/0/0",
                         i, bif.rd_en, bif.sweep_busy, bif.sweep_done, bif.out_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        int  c;
        wr_t w;
        fill_words(DEPTH, DC3, 200, c);
        step();
        @(negedge clk);
        exp_sel = 1'b1;
        check_side("mid_swap", 2'b01, 1'b1, 1'b1);
        step();
        bif.sweep_start = 1'b1;
        bif.sweep_keep  = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            step();
            bif.sweep_start = 1'b0;
            bif.in_valid    = 1'b1;
            bif.in_data     = D55;
            @(negedge clk);
            if (bif.in_ready === 1'b1) begin
                w.sel  = exp_sel;
                w.addr = exp_waddr[ADDR_W-1:0];
                w.data = D55;
                wq.push_back(w);
                exp_waddr = (exp_waddr + 1) % DEPTH;
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset_mid");
        wq.delete();
        exp_waddr = 0;
        exp_sel   = 1'b0;
        bif.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        fill_words(4, D0F, 20, c);
        checks++;
        if (c != 4) begin
            failures++;
            $display("FAIL post_reset_fill cycles=%0d expected=4", c);
        end
        step();
        @(negedge clk);
        checks++;
        if ({bif.wr_addr, bif.bank_full, bif.Bank_sel} !== {ADDR_W'(3), 2'b00, 1'b0} || wq.size() != 0) begin
            failures++;
            $display("FAIL post_reset_state got wa=%0d full=%b sel=%0b pending=%0d expected wa=3 full=00 sel=0 pending=0",
                     bif.wr_addr, bif.bank_full, bif.Bank_sel, wq.size());
        end
    endtask

    initial begin
        bif.in_valid    = 1'b0;
        bif.in_data     = '0;
        bif.sweep_start = 1'b0;
        bif.sweep_keep  = 1'b0;
        test_reset();
        test_fill_bank0();
        test_sweep_concurrent();
        test_both_full();
        test_keep();
        test_ignored();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bank_pingpong_ctrl.md
Name: bank_pingpong_ctrl

Overview:
- Sequences a pair of reference-pixel banks behind the Bank datapath in ping-pong fashion for the ME search engine.
- One bank is filled from the reference-fetch stream while the other is swept, address by address, for the SAD array.
- Owns the Bank select, write enable, write/read addresses and read enable, and handles the full/empty bookkeeping and the bank swap.

Parameters:
- PIXEL, 8, bits per pixel
- LANES, 8, pixels per bank word
- DEPTH, 128, words per bank (power of two)
- ADDR_W, 7, log2(DEPTH)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  fetch word valid
- in_ready  out  1  controller can accept a fetch word
- in_data  in  LANES*PIXEL  fetch word
- sweep_start  in  1  request a full read sweep of the ready bank
- sweep_keep  in  1  sampled with sweep_start; 1 = retain bank for a re-sweep
- sweep_busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse, last read word is valid
- beg_en  out  1  bank write enable
- ref_in  out  LANES*PIXEL  bank write data (registered in_data)
- wr_addr  out  ADDR_W  bank write address
- Bank_sel  out  1  bank currently being written; the other bank is read
- address  out  ADDR_W  bank read address
- rd_en  out  1  bank read enable, active-low
- out_valid  out  1  bank ref_ou is valid this cycle (1-cycle bank latency)
- bank_full  out  2  per-bank full flags

Behaviour:
- Reset values: in_ready=0 during reset, then 1 one cycle after release; sweep_busy=0, sweep_done=0, beg_en=0, ref_in=0, wr_addr=0, Bank_sel=0, address=0, rd_en=1 (idle), out_valid=0, bank_full=2'b00. Reset mid-fill or mid-sweep discards all contents.
- Fill side: in_ready = !bank_full[Bank_sel].
  - The transfer is in_valid && in_ready. On the next cycle beg_en=1, ref_in=word, and wr_addr = current fill count.
  - The fill count increments per transfer and wraps to 0 after DEPTH-1.
  - The write of word DEPTH-1 sets bank_full[Bank_sel] in the same cycle that beg_en is asserted. in_ready drops the cycle after the final transfer, so no DEPTH+1th word is accepted.
- Swap: when bank_full[Bank_sel]=1, bank_full[~Bank_sel]=0 and the read FSM is IDLE, Bank_sel toggles next cycle and in_ready reasserts.
  - A swap never occurs while beg_en=1 for the old bank.
- Read FSM states: IDLE, READ, DRAIN.
  - IDLE -> READ on sweep_start && bank_full[~Bank_sel]. sweep_keep is latched at this point.
  - sweep_start in any other condition is ignored, with no pulse and no error.
  - READ: rd_en=0, address steps 0..DEPTH-1, one word per cycle; sweep_busy=1.
  - out_valid follows rd_en low with 1-cycle delay, for exactly DEPTH cycles.
  - After address DEPTH-1: READ -> DRAIN, rd_en=1.
  - DRAIN: sweep_done=1 with the last out_valid. If keep=0, bank_full[~Bank_sel] clears; if keep=1, the bank is retained. Then DRAIN -> IDLE; address returns to 0.
  - Back-to-back: sweep_start in DRAIN is ignored; the earliest re-sweep start is the first IDLE cycle. Sweep-to-sweep gap is 2 cycles.
- Simultaneous events:
  - Fill and sweep run concurrently on opposite banks.
  - A swap and sweep_start can never both qualify in the same cycle, because one requires the read bank empty and the other requires it full.
  - The clear in DRAIN enables a swap on the following cycle.
  - Both banks full with read idle: no swap; in_ready stays 0 until a keep=0 sweep completes.
- Latency: fetch word to bank write is 1 cycle. sweep_start to first out_valid is 2 cycles. Full sweep is DEPTH+2 cycles.

Decomposition:
- Shared package me_dmt_pkg: PIXEL, LANES, DEPTH, ADDR_W constants; read-FSM state enum (IDLE/READ/DRAIN).
- One natural sub-module: bank_addr_gen, a DEPTH-wrapping address counter with enable, clear and last-flag outputs. It is instantiated twice, once for fill and once for sweep.

Test Plan:
- Reset release, 128 words of 8{8'h0F} streamed continuously -> wr_addr 0..127, beg_en 128 cycles, bank_full=2'b01 then Bank_sel=1, in_ready=1, bank_full stays 01.
- After the above, sweep_start (keep=0) -> rd_en low 128 cycles, address 0..127, out_valid 128 cycles starting 2 cycles after start, sweep_done coincident with the last word, bank_full -> 00.
- Concurrent: fill bank1 with 8{8'h55} during the bank0 sweep -> no stalls, both finish; swap to Bank_sel=0 on the cycle after DRAIN.
- Fill both banks (8{8'h0F}, 8{8'h33}) with no sweep -> in_ready=0 and the 257th word is held off; after one keep=0 sweep, in_ready returns within 2 cycles.
- sweep_keep=1 sweep, then a second sweep -> bank_full unchanged after the first, identical address sequence twice, no swap until the second (keep=0) completes.
- sweep_start with the read bank empty, and sweep_start during READ -> ignored, no sweep_done; rst_n low mid-sweep -> all outputs at reset values asynchronously, bank_full=00.
